// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the spi_arbiter slice.
//   state_t     : arbiter FSM states
//   PORT0/PORT1 : requester indices (port 0 = mem_ctrl, port 1 = reg/DMA master)
//   spi_fwd_t   : the control bundle a requester presents to spi_core
//   spi_fwd_mux : selects the owner's bundle, or all-zero when nobody owns the bus
package spi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OWN0  = 3'd1,
    ST_OWN1  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic       start;
    logic [7:0] data;
    logic       force_clock;
  } spi_fwd_t;

  function automatic spi_fwd_t spi_fwd_mux(input logic     en,
                                           input logic     sel,
                                           input spi_fwd_t p0,
                                           input spi_fwd_t p1);
    spi_fwd_t r;
    r = '0;
    if (en) r = sel ? p1 : p0;
    return r;
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester-side bus of spi_arbiter: both requesters' handshake, data and
// status signals, keeping the original per-port names.
//   slave  : arbiter view (requests/controls in, grants/status out)
//   master : requester view (requests/controls out, grants/status in)
interface spi_arbiter_if;

  logic       req0,         req1;
  logic       gnt0,         gnt1;
  logic       txn_start0,   txn_start1;
  logic [7:0] data_tx0,     data_tx1;
  logic       force_clock0, force_clock1;
  logic       txn_done0,    txn_done1;
  logic [7:0] data_rx0,     data_rx1;
  logic       err0,         err1;

  modport slave (
    input  req0, req1, txn_start0, txn_start1, data_tx0, data_tx1,
           force_clock0, force_clock1,
    output gnt0, gnt1, txn_done0, txn_done1, data_rx0, data_rx1, err0, err1
  );

  modport master (
    output req0, req1, txn_start0, txn_start1, data_tx0, data_tx1,
           force_clock0, force_clock1,
    input  gnt0, gnt1, txn_done0, txn_done1, data_rx0, data_rx1, err0, err1
  );

endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_core between two requesters.
// Grants whole CE-low ownership windows with round-robin tie-breaking,
// forwards the owner's start/data/force-clock to spi_core, routes done and
// rx data back to the owner only, enforces a minimum idle gap between
// owners and pulses errN on protocol misuse.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : req/gnt/txn_start/data_tx/force_clock/txn_done/
//                       data_rx/err for ports 0 and 1
//   spi_txn_start     : byte start to spi_core
//   spi_data_tx[7:0]  : byte to spi_core
//   spi_force_clock   : force-clock to spi_core
//   spi_txn_done      : byte complete from spi_core
//   spi_data_rx[7:0]  : received byte from spi_core (valid with done)
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int GAP_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_arbiter_if.slave     bus,
  output logic             spi_txn_start,
  output logic [7:0]       spi_data_tx,
  output logic             spi_force_clock,
  input  logic             spi_txn_done,
  input  logic [7:0]       spi_data_rx
);

  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

  // Release target when the owner finishes cleanly or a drain completes.
  localparam state_t ST_AFTER_OWN = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_t           state_q, state_d;
  logic             last_owner_q;
  logic             in_flight_q, in_flight_d;
  logic [GAP_W-1:0] gap_q;
  logic             gnt0_q, gnt1_q;
  logic [7:0]       data_rx0_q, data_rx1_q;

  logic             own0, own1, owning;
  logic             owner_req;
  logic             start_ok;
  spi_fwd_t         p0, p1, fwd;

  assign own0   = (state_q == ST_OWN0);
  assign own1   = (state_q == ST_OWN1);
  assign owning = own0 | own1;

  assign owner_req = own1 ? bus.req1 : bus.req0;

  assign p0  = '{start: bus.txn_start0, data: bus.data_tx0, force_clock: bus.force_clock0};
  assign p1  = '{start: bus.txn_start1, data: bus.data_tx1, force_clock: bus.force_clock1};
  assign fwd = spi_fwd_mux(owning, own1, p0, p1);

  // A start from the owner is only passed on when no byte is outstanding.
  assign start_ok        = fwd.start & ~in_flight_q;
  assign spi_txn_start   = start_ok;
  assign spi_data_tx     = fwd.data;
  assign spi_force_clock = fwd.force_clock;

  // Done is only ever routed to the current owner; during DRAIN it is swallowed.
  assign bus.txn_done0 = own0 & spi_txn_done;
  assign bus.txn_done1 = own1 & spi_txn_done;

  // Error: start without ownership, start while a byte is outstanding, or a
  // release while a byte is outstanding (unless its done lands in that cycle).
  assign bus.err0 = (bus.txn_start0 & (~own0 | in_flight_q)) |
                    (own0 & ~bus.req0 & in_flight_q & ~spi_txn_done);
  assign bus.err1 = (bus.txn_start1 & (~own1 | in_flight_q)) |
                    (own1 & ~bus.req1 & in_flight_q & ~spi_txn_done);

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.data_rx0 = data_rx0_q;
  assign bus.data_rx1 = data_rx1_q;

  always_comb begin
    state_d     = state_q;
    in_flight_d = in_flight_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 && (!bus.req1 || last_owner_q == PORT1)) state_d = ST_OWN0;
        else if (bus.req1)                                    state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (spi_txn_done)  in_flight_d = 1'b0;
        else if (start_ok) in_flight_d = 1'b1;
        if (!owner_req) begin
          if (in_flight_q && !spi_txn_done) begin
            state_d = ST_DRAIN;
          end else begin
            state_d     = ST_AFTER_OWN;
            in_flight_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (spi_txn_done) begin
          state_d     = ST_AFTER_OWN;
          in_flight_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= PORT1;
      in_flight_q  <= 1'b0;
      gap_q        <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      data_rx0_q   <= '0;
      data_rx1_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= in_flight_d;
      gnt0_q      <= (state_d == ST_OWN0);
      gnt1_q      <= (state_d == ST_OWN1);

      if (state_q == ST_IDLE && state_d == ST_OWN0) last_owner_q <= PORT0;
      if (state_q == ST_IDLE && state_d == ST_OWN1) last_owner_q <= PORT1;

      if (state_d == ST_GAP && state_q != ST_GAP)  gap_q <= GAP_LOAD;
      else if (state_q == ST_GAP && gap_q != '0)   gap_q <= gap_q - GAP_W'(1);

      if (own0 && spi_txn_done) data_rx0_q <= spi_data_rx;
      if (own1 && spi_txn_done) data_rx1_q <= spi_data_rx;
    end
  end

  a_one_grant : assert property (@(posedge clk) disable iff (!rst_n) !(gnt0_q && gnt1_q));

endmodule
